pomdp_step_sequencer: RTL and testbench
=======================================

// Module: pomdp_step_sequencer
// PURPOSE
//  Episode controller for the POMDP simulation top. Sequences each step through decision (PBVI_decision),
//  environment sampling (transition + observation), then belief update (PBVI_belief) via start/done handshakes.
//  Accumulates reward, counts steps, stops after num_steps or on abort; exports action/obs/state for display.
// PARAMETERS
//  ACT_W       2    action width (matches point_action encoding)
//  REW_W       16   per-step reward width (vec_reward entries)
//  ACC_W       32   accumulated reward width
//  CNT_W       16   step counter width
//  TIMEOUT     255  max cycles waiting on any *_done before error abort
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      asynchronous, active-high reset
//  en             in   1      episode start pulse; sampled only in IDLE
//  abort          in   1      synchronous episode abort, any state
//  initial_state  in   1      state loaded into cur_state on accepted en
//  num_steps      in   CNT_W  steps per episode, sampled on accepted en
//  dec_start      out  1      one-cycle pulse: begin action selection
//  dec_done       in   1      decision complete; dec_action valid this cycle
//  dec_action     in   ACT_W  chosen action
//  env_start      out  1      one-cycle pulse: sample next state/obs for action
//  env_done       in   1      env complete; env_state/env_obs/rew_in valid this cycle
//  env_state      in   1      next hidden state
//  env_obs        in   1      observation
//  rew_in         in   REW_W  reward of (action, pre-transition state), unsigned
//  bel_start      out  1      one-cycle pulse: update belief with (action, observation)
//  bel_done       in   1      belief update complete
//  action         out  ACT_W  last latched action
//  observation    out  1      last latched observation
//  cur_state      out  1      current hidden state
//  reward         out  ACC_W  accumulated reward, saturating
//  step_cnt       out  CNT_W  completed steps this episode
//  busy           out  1      high in every state except IDLE
//  done           out  1      one-cycle pulse on normal episode completion
//  timeout_err    out  1      sticky; set on phase timeout, cleared on next accepted en
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0 (action, observation, cur_state, reward, step_cnt, busy, done, starts, err).
//  - FSM: IDLE -> DECIDE -> ENV -> BELIEF -> CHECK -> (DECIDE | FINISH) ; FINISH -> IDLE.
//  - IDLE: en=1 -> load cur_state=initial_state, reward=0, step_cnt=0, timeout_err=0, latch num_steps;
//    if num_steps==0 go FINISH else DECIDE. en in any other state ignored.
//  - Each of DECIDE/ENV/BELIEF: its *_start high exactly on first cycle in state; wait for matching *_done
//    (may arrive earliest the cycle after start). *_done outside its own wait state is ignored.
//  - DECIDE: on dec_done latch action<=dec_action -> ENV.
//  - ENV: on env_done cur_state<=env_state, observation<=env_obs, reward<=sat(reward+rew_in) -> BELIEF.
//  - BELIEF: on bel_done -> CHECK. CHECK (1 cycle): step_cnt++; if new step_cnt==num_steps -> FINISH else DECIDE.
//  - Min step latency 7 cycles (3 waits of 2 + CHECK) with done one cycle after each start.
//  - FINISH: done=1 for one cycle -> IDLE; outputs hold values until next accepted en.
//  - Saturation: reward sticks at 2^ACC_W-1, never wraps. step_cnt never exceeds num_steps.
//  - Timeout: phase cycle counter resets on state entry; reaching TIMEOUT without done -> timeout_err=1,
//    IDLE next cycle, no done pulse; action/obs/state/reward/step_cnt hold.
//  - abort=1: IDLE next cycle from any state, no done, no err; has priority over *_done and timeout same cycle.
//  - rst mid-episode: immediate return to reset values; no start pulse emitted after release until en.
// STRUCTURE
//  - pomdp_pkg: step_state_e enum {IDLE,DECIDE,ENV,BELIEF,CHECK,FINISH}, ACT_W/REW_W/ACC_W consts,
//    sat_add() function.
//  - Sub-module pomdp_phase_timer: per-phase cycle counter with clear-on-entry and expired flag.
// TESTING
//  - rst, initial_state=0, num_steps=3, stubs done 1 cycle after start, rew_in=7209 -> 3 dec/env/bel pulses,
//    reward=21627, step_cnt=3, single done pulse.
//  - num_steps=0, en -> done pulse 2 cycles after en, no *_start pulses, reward=0.
//  - rew_in=16'hFFFF, reward preloaded near max via many steps (ACC_W=17 override) -> reward clamps at 2^17-1.
//  - bel_done withheld, TIMEOUT=8 -> timeout_err=1 on 9th wait cycle, busy=0 next cycle, no done; next en clears err.
//  - abort asserted same cycle as env_done -> IDLE, cur_state/reward unchanged, no done.
//  - en while busy, stray dec_done in ENV -> ignored; step count and pulse sequence identical to clean run.

Source files
------------

// File: rtl/pomdp_pkg.sv
// pomdp_pkg: step-sequencer FSM states, default widths and saturating accumulate.
package pomdp_pkg;
    localparam int ACT_W = 2;
    localparam int REW_W = 16;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;
    typedef enum logic [2:0] {IDLE, DECIDE, ENV, BELIEF, CHECK, FINISH} step_state_e;
    // add two unsigned values and clamp to the largest w-bit value instead of wrapping
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        return s > m ? m[63:0] : s[63:0];
    endfunction
endpackage

// File: rtl/pomdp_step_sequencer_if.sv
// pomdp_step_sequencer_if: start/done handshakes to the decision, environment and belief engines.
interface pomdp_step_sequencer_if #(
    parameter int ACT_W = 2,
    parameter int REW_W = 16
);
    logic             dec_start;
    logic             dec_done;
    logic [ACT_W-1:0] dec_action;
    logic             env_start;
    logic             env_done;
    logic             env_state;
    logic             env_obs;
    logic [REW_W-1:0] rew_in;
    logic             bel_start;
    logic             bel_done;
    modport master (
        output dec_start, env_start, bel_start,
        input  dec_done, dec_action, env_done, env_state, env_obs, rew_in, bel_done
    );
    modport slave (
        input  dec_start, env_start, bel_start,
        output dec_done, dec_action, env_done, env_state, env_obs, rew_in, bel_done
    );
endinterface

// File: rtl/pomdp_phase_timer.sv
// pomdp_phase_timer: cycles spent in the current phase; clr marks the phase entry cycle.
module pomdp_phase_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1) + 1;
    logic [W-1:0] cnt;
    // the entry cycle counts as 0, so the register holds 1 from the following cycle; it saturates
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= W'(1);
        else if (cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
    assign expired = !clr && cnt == W'(TIMEOUT);
endmodule

// File: rtl/pomdp_step_sequencer.sv
// pomdp_step_sequencer: episode controller running decide -> environment -> belief per step,
// accumulating reward until num_steps complete, abort, or a phase timeout.
module pomdp_step_sequencer
    import pomdp_pkg::*;
#(
    parameter int ACT_W   = pomdp_pkg::ACT_W,
    parameter int REW_W   = pomdp_pkg::REW_W,
    parameter int ACC_W   = pomdp_pkg::ACC_W,
    parameter int CNT_W   = pomdp_pkg::CNT_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  abort,
    input  logic                  initial_state,
    input  logic [CNT_W-1:0]      num_steps,
    pomdp_step_sequencer_if.master ph,
    output logic [ACT_W-1:0]      action,
    output logic                  observation,
    output logic                  cur_state,
    output logic [ACC_W-1:0]      reward,
    output logic [CNT_W-1:0]      step_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);
    step_state_e      state;
    logic [CNT_W-1:0] n_steps;
    logic [CNT_W-1:0] next_cnt;
    logic [REW_W-1:0] rew;
    logic             expired;
    assign next_cnt = step_cnt + 1'b1;
    assign rew      = ph.rew_in;
    assign busy     = state != IDLE;
    // every wait-state entry carries its start pulse, which doubles as the timer clear
    pomdp_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(ph.dec_start | ph.env_start | ph.bel_start),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= IDLE;
            n_steps      <= '0;
            action       <= '0;
            observation  <= 1'b0;
            cur_state    <= 1'b0;
            reward       <= '0;
            step_cnt     <= '0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            ph.dec_start <= 1'b0;
            ph.env_start <= 1'b0;
            ph.bel_start <= 1'b0;
        end else begin
            ph.dec_start <= 1'b0;
            ph.env_start <= 1'b0;
            ph.bel_start <= 1'b0;
            done         <= 1'b0;
            if (abort) state <= IDLE;
            else case (state)
                IDLE: if (en) begin
                    cur_state   <= initial_state;
                    reward      <= '0;
                    step_cnt    <= '0;
                    timeout_err <= 1'b0;
                    n_steps     <= num_steps;
                    state       <= num_steps == '0 ? FINISH : DECIDE;
                    ph.dec_start <= num_steps != '0;
                end
                DECIDE: if (ph.dec_done) begin
                    action       <= ph.dec_action;
                    state        <= ENV;
                    ph.env_start <= 1'b1;
                end else if (expired) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end
                ENV: if (ph.env_done) begin
                    cur_state    <= ph.env_state;
                    observation  <= ph.env_obs;
                    reward       <= ACC_W'(sat_add(64'(reward), 64'(rew), ACC_W));
                    state        <= BELIEF;
                    ph.bel_start <= 1'b1;
                end else if (expired) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end
                BELIEF: if (ph.bel_done) state <= CHECK;
                else if (expired) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end
                CHECK: begin
                    step_cnt     <= next_cnt;
                    state        <= next_cnt == n_steps ? FINISH : DECIDE;
                    ph.dec_start <= next_cnt != n_steps;
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_pomdp_step_sequencer.sv
// tb_pomdp_step_sequencer: randomized episodes with responder stubs, checked against
// a model of the episode rules (latched values, saturating reward sum, pulse counts).
module tb_pomdp_step_sequencer;
    localparam int     TMO  = 8;
    localparam longint RMAX = (longint'(1) << 17) - 1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        abort = 1'b0;
    logic        initial_state = 1'b0;
    logic [15:0] num_steps = '0;
    logic [1:0]  action;
    logic        observation;
    logic        cur_state;
    logic [16:0] reward;
    logic [15:0] step_cnt;
    logic        busy;
    logic        done;
    logic        timeout_err;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dec_t = -1, env_t = -1, bel_t = -1;
    int lat_fixed = 1, abort_idx = -1, env_cnt = 0;
    bit hold = 0, stray = 0, rew_rand = 0;
    logic [15:0] rew_fixed = '0;
    int n_dec, n_env, n_bel, n_done, en_cyc, done_at, err_at, bel_seen;
    logic busy_at_err;
    logic [1:0] exp_act = '0;
    logic exp_st = 1'b0, exp_obs = 1'b0;
    longint exp_rew = 0;
    int exp_steps = 0;
    pomdp_step_sequencer_if #(.ACT_W(2), .REW_W(16)) ph ();
    pomdp_step_sequencer #(.ACC_W(17), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .abort(abort), .initial_state(initial_state),
        .num_steps(num_steps), .ph(ph), .action(action), .observation(observation),
        .cur_state(cur_state), .reward(reward), .step_cnt(step_cnt), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    function automatic int lat_pick();
        return lat_fixed > 0 ? lat_fixed : int'($urandom_range(4, 1));
    endfunction
    task automatic clear_resp();
        dec_t = -1; env_t = -1; bel_t = -1;
        ph.dec_done = 1'b0; ph.env_done = 1'b0; ph.bel_done = 1'b0;
        ph.dec_action = '0; ph.env_state = 1'b0; ph.env_obs = 1'b0; ph.rew_in = '0;
    endtask
    // one cycle: observe at the falling edge, then drive stub responses for the next rising edge
    task automatic step();
        logic d, e, b;
        @(negedge clk);
        cyc++;
        n_dec += int'(ph.dec_start);
        n_env += int'(ph.env_start);
        n_bel += int'(ph.bel_start);
        n_done += int'(done);
        if (ph.bel_start) bel_seen = cyc;
        if (hold && timeout_err && err_at < 0) begin
            err_at = cyc - bel_seen;
            busy_at_err = busy;
        end
        d = dec_t == 0;
        e = env_t == 0;
        b = bel_t == 0;
        ph.dec_done = d || (stray && env_t > 0 && $urandom_range(1) == 1);
        ph.dec_action = 2'($urandom);
        if (d) exp_act = ph.dec_action;
        ph.env_done = e;
        ph.env_state = 1'($urandom);
        ph.env_obs = 1'($urandom);
        ph.rew_in = rew_rand ? 16'($urandom) : rew_fixed;
        abort = e && env_cnt == abort_idx;
        if (e) begin
            if (!abort) begin
                exp_st = ph.env_state;
                exp_obs = ph.env_obs;
                exp_rew = exp_rew + longint'(ph.rew_in) > RMAX ? RMAX : exp_rew + longint'(ph.rew_in);
            end
            env_cnt++;
        end
        ph.bel_done = b;
        if (b) exp_steps++;
        en = stray && busy && $urandom_range(1) == 1;
        if (dec_t >= 0) dec_t--;
        if (env_t >= 0) env_t--;
        if (bel_t >= 0) bel_t--;
        if (ph.dec_start) dec_t = lat_pick() - 1;
        if (ph.env_start) env_t = lat_pick() - 1;
        if (ph.bel_start && !hold) bel_t = lat_pick() - 1;
    endtask
    task automatic run_ep(input int n, input logic init);
        bit fin;
        n_dec = 0; n_env = 0; n_bel = 0; n_done = 0;
        exp_rew = 0; exp_st = init; exp_steps = 0; env_cnt = 0;
        done_at = -1; err_at = -1; busy_at_err = 1'bx; bel_seen = 0;
        step();
        en = 1'b1;
        initial_state = init;
        num_steps = 16'(n);
        en_cyc = cyc;
        fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            step();
            if (done && done_at < 0) done_at = cyc - en_cyc;
            fin = !busy;
        end
        check("episode_ends_in_budget", 64'(fin), 64'(1));
        repeat (2) step();
    endtask
    task automatic ep_checks(input string t, input int nd, input int ne, input int nb, input int ndn, input logic err);
        check({t, "_action"}, 64'(action), 64'(exp_act));
        check({t, "_obs"}, 64'(observation), 64'(exp_obs));
        check({t, "_state"}, 64'(cur_state), 64'(exp_st));
        check({t, "_reward"}, 64'(reward), 64'(exp_rew));
        check({t, "_steps"}, 64'(step_cnt), 64'(exp_steps));
        check({t, "_dec_pulses"}, 64'(n_dec), 64'(nd));
        check({t, "_env_pulses"}, 64'(n_env), 64'(ne));
        check({t, "_bel_pulses"}, 64'(n_bel), 64'(nb));
        check({t, "_done_pulses"}, 64'(n_done), 64'(ndn));
        check({t, "_err"}, 64'(timeout_err), 64'(err));
        check({t, "_busy"}, 64'(busy), 64'(0));
    endtask
    initial begin
        clear_resp();
        repeat (2) @(negedge clk);
        check("rst_action", 64'(action), 64'(0));
        check("rst_obs", 64'(observation), 64'(0));
        check("rst_state", 64'(cur_state), 64'(0));
        check("rst_reward", 64'(reward), 64'(0));
        check("rst_steps", 64'(step_cnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(timeout_err), 64'(0));
        check("rst_starts", 64'({ph.dec_start, ph.env_start, ph.bel_start}), 64'(0));
        rst = 1'b0;
        lat_fixed = 1; rew_rand = 0; rew_fixed = 16'd7209;
        run_ep(3, 1'b0);
        ep_checks("basic", 3, 3, 3, 1, 1'b0);
        check("basic_reward_const", 64'(reward), 64'(21627));
        check("basic_steps_const", 64'(step_cnt), 64'(3));
        run_ep(0, 1'b1);
        ep_checks("zero", 0, 0, 0, 1, 1'b0);
        check("zero_done_latency", 64'(done_at), 64'(2));
        rew_fixed = 16'hFFFF;
        run_ep(4, 1'b0);
        ep_checks("sat", 4, 4, 4, 1, 1'b0);
        check("sat_clamp", 64'(reward), 64'(RMAX));
        lat_fixed = 0; rew_rand = 1; hold = 1;
        run_ep(2, 1'b1);
        hold = 0;
        ep_checks("tmo", 1, 1, 1, 0, 1'b1);
        check("tmo_latency", 64'(err_at), 64'(TMO + 1));
        check("tmo_busy_low", 64'(busy_at_err), 64'(0));
        run_ep(1, 1'b0);
        ep_checks("tmo_clear", 1, 1, 1, 1, 1'b0);
        abort_idx = 1;
        run_ep(3, 1'b1);
        abort_idx = -1;
        ep_checks("abort", 2, 2, 1, 0, 1'b0);
        stray = 1;
        run_ep(4, 1'b0);
        stray = 0;
        ep_checks("stray", 4, 4, 4, 1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(5, 1));
            run_ep(n, 1'($urandom));
            ep_checks("rand", n, n, n, 1, 1'b0);
        end
        step();
        en = 1'b1; initial_state = 1'b1; num_steps = 16'd5;
        repeat (9) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_reward", 64'(reward), 64'(0));
        check("midrst_steps", 64'(step_cnt), 64'(0));
        check("midrst_state", 64'(cur_state), 64'(0));
        check("midrst_action", 64'(action), 64'(0));
        check("midrst_starts", 64'({ph.dec_start, ph.env_start, ph.bel_start}), 64'(0));
        clear_resp();
        exp_act = '0; exp_obs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_dec = 0; n_env = 0; n_bel = 0;
        repeat (10) step();
        check("midrst_no_start", 64'(n_dec + n_env + n_bel), 64'(0));
        check("midrst_idle", 64'(busy), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
